// File: rtl/fir_err_monitor_if.sv
// fir_err_monitor bus bundle
// Filter-side inputs and measured error metrics
interface fir_err_monitor_if #(
  parameter int XW   = 8,
  parameter int YW   = 16,
  parameter int ACCW = 32
) ();
  logic            Start;
  logic [XW-1:0]   Xin;
  logic [YW-1:0]   Yapprox;
  logic            Busy;
  logic            Done;
  logic [15:0]     ErrCount;
  logic [YW-1:0]   MaxErr;
  logic [ACCW-1:0] SumAbsErr;

  modport master (
    output Start, Xin, Yapprox,
    input  Busy, Done, ErrCount,
    input  MaxErr, SumAbsErr
  );

  modport slave (
    input  Start, Xin, Yapprox,
    output Busy, Done, ErrCount,
    output MaxErr, SumAbsErr
  );
endinterface

// File: rtl/fir_err_monitor.sv
// fir_err_monitor: rebuilds the exact FIR result and
// accumulates error metrics of an approximate filter
module fir_err_monitor #(
  parameter int XW      = 8,
  parameter int YW      = 16,
  parameter int H0      = -2,
  parameter int H1      = -1,
  parameter int H2      = 3,
  parameter int H3      = 4,
  parameter int DELAYED = 0,
  parameter int LAT     = 1,
  parameter int WINDOW  = 256,
  parameter int ACCW    = 32
) (
  input logic         Clk,
  input logic         Rst,
  fir_err_monitor_if.slave bus
);

  localparam int HIST  = (DELAYED != 0) ? 3 : 0;
  localparam int NFILL = LAT + HIST - 1;
  localparam int FCW   =
    (NFILL < 2) ? 1 : $clog2(NFILL);
  localparam int SCW   =
    (WINDOW < 2) ? 1 : $clog2(WINDOW);
  localparam int SW    =
    ((ACCW > YW) ? ACCW : YW) + 1;

  localparam logic [YW-1:0] C0 = YW'(H0);
  localparam logic [YW-1:0] C1 = YW'(H1);
  localparam logic [YW-1:0] C2 = YW'(H2);
  localparam logic [YW-1:0] C3 = YW'(H3);
  localparam logic [YW-1:0] CS =
    YW'(H0 + H1 + H2 + H3);
  localparam logic [SW-1:0] SUM_MAX =
    SW'({ACCW{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [XW-1:0]   x1_q, x2_q, x3_q;
  logic [YW-1:0]   ref_q [LAT];
  logic [FCW-1:0]  fill_q, fill_d;
  logic [SCW-1:0]  samp_q, samp_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [YW-1:0]   max_q, max_d;
  logic [ACCW-1:0] sum_q, sum_d;

  logic [YW-1:0]   xe0, xe1, xe2, xe3;
  logic [YW-1:0]   yref;
  logic [YW-1:0]   yal;
  logic [YW-1:0]   d;
  logic [YW-1:0]   absd;
  logic [SW-1:0]   sum_ext;
  logic [ACCW-1:0] sum_sat;

  // Sample history for the delayed taps, runs always
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      x1_q <= '0;
      x2_q <= '0;
      x3_q <= '0;
    end else begin
      x1_q <= bus.Xin;
      x2_q <= x1_q;
      x3_q <= x2_q;
    end
  end

  // Exact reference, modulo 2^YW
  always_comb begin
    xe0 = YW'(bus.Xin);
    xe1 = YW'(x1_q);
    xe2 = YW'(x2_q);
    xe3 = YW'(x3_q);
    if (DELAYED != 0) begin
      yref = C0 * xe0 + C1 * xe1
           + C2 * xe2 + C3 * xe3;
    end else begin
      yref = CS * xe0;
    end
  end

  // Delay the reference to line up with Yapprox
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < LAT; i++) begin
        ref_q[i] <= '0;
      end
    end else begin
      ref_q[0] <= yref;
      for (int i = 1; i < LAT; i++) begin
        ref_q[i] <= ref_q[i-1];
      end
    end
  end

  // Signed error magnitude and saturating sum
  always_comb begin
    yal     = ref_q[LAT-1];
    d       = bus.Yapprox - yal;
    absd    = d[YW-1] ? (~d + 1'b1) : d;
    sum_ext = SW'(sum_q) + SW'(absd);
    if (sum_ext > SUM_MAX) begin
      sum_sat = {ACCW{1'b1}};
    end else begin
      sum_sat = sum_ext[ACCW-1:0];
    end
  end

  // Run sequencing and metric accumulation
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    samp_d  = samp_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    sum_d   = sum_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          cnt_d  = '0;
          max_d  = '0;
          sum_d  = '0;
          samp_d = '0;
          if (NFILL == 0) begin
            state_d = S_RUN;
          end else begin
            state_d = S_FILL;
            fill_d  = FCW'(NFILL - 1);
          end
        end
      end
      S_FILL: begin
        if (fill_q == '0) begin
          state_d = S_RUN;
        end else begin
          fill_d = fill_q - 1'b1;
        end
      end
      S_RUN: begin
        if (d != '0 && cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (absd > max_q) begin
          max_d = absd;
        end
        sum_d = sum_sat;
        if (samp_q == SCW'(WINDOW - 1)) begin
          state_d = S_DONE;
        end else begin
          samp_d = samp_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      fill_q  <= '0;
      samp_q  <= '0;
      cnt_q   <= '0;
      max_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      samp_q  <= samp_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
    end
  end

  assign bus.Busy      = (state_q == S_FILL)
                      || (state_q == S_RUN);
  assign bus.Done      = (state_q == S_DONE);
  assign bus.ErrCount  = cnt_q;
  assign bus.MaxErr    = max_q;
  assign bus.SumAbsErr = sum_q;

endmodule

// File: tb/tb_fir_err_monitor.sv
// tb_fir_err_monitor: three monitor configurations
// driven in parallel against a cycle-indexed model
module tb_fir_err_monitor;

  localparam int LATK [3] = '{1, 1, 2};
  localparam int DELK [3] = '{0, 0, 1};
  localparam int WK   [3] = '{4, 4, 4};
  localparam int NK   [3] = '{0, 0, 4};
  localparam int ACCK [3] = '{32, 16, 32};
  localparam int HT   [4] = '{-2, -1, 3, 4};

  logic clk = 1'b0;
  logic rst;
  logic start_r;
  logic [7:0]  xin_r;
  logic [15:0] yap [3];

  always #5 clk = ~clk;

  fir_err_monitor_if #(.XW(8), .YW(16), .ACCW(32))
    ifa ();
  fir_err_monitor_if #(.XW(8), .YW(16), .ACCW(16))
    ifb ();
  fir_err_monitor_if #(.XW(8), .YW(16), .ACCW(32))
    ifc ();

  assign ifa.Start   = start_r;
  assign ifa.Xin     = xin_r;
  assign ifa.Yapprox = yap[0];
  assign ifb.Start   = start_r;
  assign ifb.Xin     = xin_r;
  assign ifb.Yapprox = yap[1];
  assign ifc.Start   = start_r;
  assign ifc.Xin     = xin_r;
  assign ifc.Yapprox = yap[2];

  fir_err_monitor #(
    .DELAYED(0), .LAT(1), .WINDOW(4), .ACCW(32)
  ) u_a (.Clk(clk), .Rst(rst), .bus(ifa));

  fir_err_monitor #(
    .DELAYED(0), .LAT(1), .WINDOW(4), .ACCW(16)
  ) u_b (.Clk(clk), .Rst(rst), .bus(ifb));

  fir_err_monitor #(
    .DELAYED(1), .LAT(2), .WINDOW(4), .ACCW(32)
  ) u_c (.Clk(clk), .Rst(rst), .bus(ifc));

  logic        busy_w [3];
  logic        done_w [3];
  logic [15:0] cnt_w  [3];
  logic [15:0] max_w  [3];
  logic [31:0] sum_w  [3];

  assign busy_w[0] = ifa.Busy;
  assign busy_w[1] = ifb.Busy;
  assign busy_w[2] = ifc.Busy;
  assign done_w[0] = ifa.Done;
  assign done_w[1] = ifb.Done;
  assign done_w[2] = ifc.Done;
  assign cnt_w[0]  = ifa.ErrCount;
  assign cnt_w[1]  = ifb.ErrCount;
  assign cnt_w[2]  = ifc.ErrCount;
  assign max_w[0]  = ifa.MaxErr;
  assign max_w[1]  = ifb.MaxErr;
  assign max_w[2]  = ifc.MaxErr;
  assign sum_w[0]  = ifa.SumAbsErr;
  assign sum_w[1]  = {16'h0, ifb.SumAbsErr};
  assign sum_w[2]  = ifc.SumAbsErr;

  int n_assert = 0;
  int n_fail   = 0;

  int     cyc     = 0;
  int     rst_cyc = 0;
  int     err_r   = 0;
  int     xh [4096];
  bit     act   [3];
  int     s_m   [3];
  int     m_cnt [3];
  int     m_max [3];
  longint m_sum [3];

  task automatic chk(
    input string nm, input int k,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got %0h expected %0h",
               nm, k, got, exp);
    end
  endtask

  function automatic int xv(input int j);
    if (j <= rst_cyc || j < 0 || j >= 4096)
      return 0;
    return xh[j];
  endfunction

  function automatic int fir(input int k,
                             input int i);
    int acc;
    acc = 0;
    if (DELK[k] != 0) begin
      for (int t = 0; t < 4; t++)
        acc += HT[t] * xv(i - t);
    end else begin
      acc = (HT[0] + HT[1] + HT[2] + HT[3])
          * xv(i);
    end
    return acc & 32'h0000FFFF;
  endfunction

  task automatic model_reset();
    rst_cyc = cyc;
    for (int k = 0; k < 3; k++) begin
      act[k]   = 1'b0;
      s_m[k]   = 0;
      m_cnt[k] = 0;
      m_max[k] = 0;
      m_sum[k] = 0;
    end
  endtask

  task automatic model_step();
    int dd, ad, n;
    longint lim;
    if (rst) begin
      model_reset();
      return;
    end
    if (cyc < 4096) xh[cyc] = int'(xin_r);
    for (int k = 0; k < 3; k++) begin
      n = NK[k];
      lim = (64'd1 << ACCK[k]) - 1;
      if (act[k] && cyc >= s_m[k] + n + 1
          && cyc <= s_m[k] + n + WK[k]) begin
        dd = (int'(yap[k]) - fir(k, cyc - LATK[k]))
           & 32'h0000FFFF;
        ad = (dd >= 32768) ? 65536 - dd : dd;
        if (dd != 0 && m_cnt[k] < 65535)
          m_cnt[k]++;
        if (ad > m_max[k]) m_max[k] = ad;
        m_sum[k] += ad;
        if (m_sum[k] > lim) m_sum[k] = lim;
      end
      if (start_r && (!act[k] ||
          cyc >= s_m[k] + n + WK[k] + 2)) begin
        act[k]   = 1'b1;
        s_m[k]   = cyc;
        m_cnt[k] = 0;
        m_max[k] = 0;
        m_sum[k] = 0;
      end
    end
  endtask

  task automatic tick();
    for (int k = 0; k < 3; k++)
      yap[k] = 16'((fir(k, cyc + 1 - LATK[k])
                    + err_r) & 32'h0000FFFF);
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    bit eb, ed;
    int e;
    for (int k = 0; k < 3; k++) begin
      e  = s_m[k] + NK[k] + WK[k];
      eb = act[k] && cyc >= s_m[k] && cyc < e;
      ed = act[k] && cyc == e;
      chk("busy", k, 64'(busy_w[k]), 64'(eb));
      chk("done", k, 64'(done_w[k]), 64'(ed));
      chk("errcount", k, 64'(cnt_w[k]),
          64'(m_cnt[k]));
      chk("maxerr", k, 64'(max_w[k]),
          64'(m_max[k]));
      chk("sumabserr", k, 64'(sum_w[k]),
          64'(m_sum[k]));
    end
  end

  task automatic lit(
    input string nm, input int k,
    input int c, input int m, input int s
  );
    chk({nm, "_cnt"}, k, 64'(cnt_w[k]), 64'(c));
    chk({nm, "_max"}, k, 64'(max_w[k]), 64'(m));
    chk({nm, "_sum"}, k, 64'(sum_w[k]), 64'(s));
  endtask

  task automatic run(
    input int mode, input int xval,
    input int e, input bit extra,
    output int da, output int dc
  );
    int s0;
    err_r = e;
    da = -1;
    dc = -1;
    for (int i = 0; i < 4; i++) begin
      xin_r = (mode != 0) ? 8'd0 : 8'(xval);
      tick();
    end
    start_r = 1'b1;
    xin_r = (mode != 0) ? 8'd1 : 8'(xval);
    tick();
    start_r = 1'b0;
    s0 = cyc;
    for (int i = 1; i < 40 && (da < 0 || dc < 0);
         i++) begin
      xin_r = (mode != 0) ? 8'(1 + i)
                          : 8'(xval);
      start_r = extra && (i == 2 || i == 5);
      tick();
      if (done_w[0] === 1'b1 && da < 0)
        da = cyc - s0;
      if (done_w[2] === 1'b1 && dc < 0)
        dc = cyc - s0;
    end
    start_r = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int da, dc;
    rst     = 1'b1;
    start_r = 1'b0;
    xin_r   = 8'd0;
    for (int k = 0; k < 3; k++) yap[k] = 16'd0;
    for (int i = 0; i < 4096; i++) xh[i] = 0;
    model_reset();
    repeat (3) tick();
    chk("rst_busy", 0, 64'(busy_w[0]), 64'd0);
    chk("rst_done", 2, 64'(done_w[2]), 64'd0);
    lit("rst", 0, 0, 0, 0);
    #1 rst = 1'b0;
    repeat (2) tick();

    run(0, 10, 0, 1'b0, da, dc);
    chk("lat_a", 0, 64'(da), 64'd4);
    chk("lat_c", 2, 64'(dc), 64'd8);
    lit("exact", 0, 0, 0, 0);

    run(0, 10, 7, 1'b0, da, dc);
    lit("err7", 0, 4, 7, 28);
    lit("err7", 2, 4, 7, 28);

    run(0, 0, -1, 1'b0, da, dc);
    lit("neg1", 0, 4, 1, 4);

    run(0, 0, 32768, 1'b0, da, dc);
    lit("sat16", 1, 4, 32768, 65535);
    lit("sat32", 0, 4, 32768, 131072);

    run(1, 0, 0, 1'b1, da, dc);
    chk("ramp_lat_a", 0, 64'(da), 64'd4);
    chk("ramp_lat_c", 2, 64'(dc), 64'd8);
    lit("ramp", 0, 0, 0, 0);
    lit("ramp", 2, 0, 0, 0);

    err_r = 7;
    xin_r = 8'd10;
    repeat (4) tick();
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
    tick();
    tick();
    chk("mid_cnt", 0, 64'(cnt_w[0]), 64'd2);
    chk("mid_busy", 0, 64'(busy_w[0]), 64'd1);
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("arst_busy", 0, 64'(busy_w[0]), 64'd0);
    chk("arst_busy", 2, 64'(busy_w[2]), 64'd0);
    chk("arst_done", 0, 64'(done_w[0]), 64'd0);
    lit("arst", 0, 0, 0, 0);
    repeat (2) tick();
    #1 rst = 1'b0;
    tick();

    run(0, 10, 7, 1'b0, da, dc);
    chk("post_lat_a", 0, 64'(da), 64'd4);
    chk("post_lat_c", 2, 64'(dc), 64'd8);
    lit("post", 0, 4, 7, 28);

    $display(
      "End of test - %0d assertions evaluated, %0d failures",
      n_assert, n_fail);
    $finish;
  end

endmodule
